inv_mix_columns_iter: RTL and testbench

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/inv_mix_col.sv | 42 ++++
 rtl/inv_mix_columns_iter.sv | 114 +++++++++++
 tb/tb_inv_mix_columns_iter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: control FSM encoding, GF(2^8) reduction constant,
// InvMixColumns coefficients and the xtime/multiply helpers built on them.
package aes_pkg;

  // Control states of the iterative InvMixColumns engine
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } imc_state_e;

  // Low byte of the field polynomial x^8+x^4+x^3+x+1
  localparam logic [7:0] GfReduce = 8'h1B;

  // InvMixColumns matrix row 0; later rows are right rotations of it
  localparam logic [7:0] CoefE = 8'h0E;
  localparam logic [7:0] CoefB = 8'h0B;
  localparam logic [7:0] CoefD = 8'h0D;
  localparam logic [7:0] Coef9 = 8'h09;

  // Multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? GfReduce : 8'h00);
  endfunction

  // Multiply by a 4-bit constant given precomputed powers v, 2v, 4v, 8v
  function automatic logic [7:0] gf_mul_pow(input logic [3:0] coef,
                                            input logic [7:0] x1,
                                            input logic [7:0] x2,
                                            input logic [7:0] x4,
                                            input logic [7:0] x8);
    logic [7:0] r;
    r = 8'h00;
    if (coef[0]) r = r ^ x1;
    if (coef[1]) r = r ^ x2;
    if (coef[2]) r = r ^ x4;
    if (coef[3]) r = r ^ x8;
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational InvMixColumns on a single 32-bit column. Byte [31:24] is row 0.
// Each byte goes through one xtime chain (x2, x4, x8); the 0e/0b/0d/09
// products are XOR combinations of those powers.
module inv_mix_col
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x4  [4];
  logic [7:0] x8  [4];
  logic [7:0] pe  [4];
  logic [7:0] pb  [4];
  logic [7:0] pd  [4];
  logic [7:0] p9  [4];

  // Per-byte xtime chain and the four constant products
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_i[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      pe[i] = gf_mul_pow(CoefE[3:0], a[i], x2[i], x4[i], x8[i]);
      pb[i] = gf_mul_pow(CoefB[3:0], a[i], x2[i], x4[i], x8[i]);
      pd[i] = gf_mul_pow(CoefD[3:0], a[i], x2[i], x4[i], x8[i]);
      p9[i] = gf_mul_pow(Coef9[3:0], a[i], x2[i], x4[i], x8[i]);
    end
  end

  // Matrix rows: circulant rotation of (0e, 0b, 0d, 09)
  always_comb begin
    col_o[31:24] = pe[0] ^ pb[1] ^ pd[2] ^ p9[3];
    col_o[23:16] = p9[0] ^ pe[1] ^ pb[2] ^ pd[3];
    col_o[15:8]  = pd[0] ^ p9[1] ^ pe[2] ^ pb[3];
    col_o[7:0]   = pb[0] ^ pd[1] ^ p9[2] ^ pe[3];
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: one shared column datapath transforms the captured
// state in place, one column per cycle, behind a valid/ready handshake on both
// sides. The result register is only exposed (out_valid) once all columns are
// done, and a new state may be accepted in the same cycle the result drains.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned N_COLS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*N_COLS-1:0]  state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*N_COLS-1:0]  NewState
);

  localparam int unsigned DataW = 32 * N_COLS;
  localparam int unsigned CntW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [CntW-1:0] LastCol = CntW'(N_COLS - 1);

  imc_state_e       fsm_q;
  logic [CntW-1:0]  cnt_q;
  logic [DataW-1:0] data_q;
  logic             out_valid_q;

  logic [31:0]      col_in;
  logic [31:0]      col_out;
  logic [DataW-1:0] data_col_d;
  logic             accept;

  // Ready in IDLE, or in DONE when the result drains this cycle
  assign in_ready = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign NewState  = data_q;

  // Select the column addressed by the counter; column 0 is the top word
  always_comb begin
    col_in = '0;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (cnt_q == CntW'(c)) begin
        col_in = data_q[DataW-1-32*c -: 32];
      end
    end
  end

  inv_mix_col u_inv_mix_col (
    .col_i (col_in),
    .col_o (col_out)
  );

  // Data register with the current column replaced by its transform
  always_comb begin
    data_col_d = data_q;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (cnt_q == CntW'(c)) begin
        data_col_d[DataW-1-32*c -: 32] = col_out;
      end
    end
  end

  // Control FSM with registered out_valid, column counter and data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (accept) begin
            data_q <= state;
            cnt_q  <= '0;
            fsm_q  <= StBusy;
          end
        end
        StBusy: begin
          data_q <= data_col_d;
          if (cnt_q == LastCol) begin
            cnt_q       <= '0;
            fsm_q       <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Back-to-back: capture the next state while the result drains
            if (in_valid) begin
              data_q <= state;
              cnt_q  <= '0;
              fsm_q  <= StBusy;
            end else begin
              fsm_q <= StIdle;
            end
          end
        end
        default: begin
          fsm_q       <= StIdle;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter: known AES vectors, fixed points,
// MixColumns round trip, backpressure with back-to-back accept, and reset.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] NewState;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.N_COLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state     (state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .NewState  (NewState)
  );

  localparam logic [127:0] VecIn    = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VecOut   = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VecFixed = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build round-trip stimulus
  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present s until accepted; returns with the accepting edge just past
  task automatic accept(input logic [127:0] s, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    state = s;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    ok = in_ready;
    step();
    in_valid = 1'b0;
    state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    state = VecIn;
    #3;
    tests++;
    if (out_valid !== 1'b0 || NewState !== '0) begin
      fails++;
      $display("FAIL reset_outputs: out_valid=%b NewState=%h, want 0 and 0", out_valid, NewState);
    end
    step();
    step();
    tests++;
    if (NewState !== '0) begin
      fails++;
      $display("FAIL reset_hold: NewState=%h, want 0", NewState);
    end
    #2;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_column();
    bit ok;
    int lat;
    accept({32'h8e4da1bc, 96'h0}, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_accept: in_ready=%b, want 1", ok);
    end
    wait_out(lat);
    tests++;
    if (lat != 4) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles, want 4", lat);
    end
    tests++;
    if (NewState[127:96] !== 32'hdb135345 || NewState[95:0] !== 96'h0) begin
      fails++;
      $display("FAIL single_column: NewState=%h, want db135345 followed by zeros", NewState);
    end
    drain();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_drain: out_valid=%b in_ready=%b, want 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_state();
    bit ok;
    int lat;
    accept(VecIn, ok);
    wait_out(lat);
    tests++;
    if (!ok || lat != 4) begin
      fails++;
      $display("FAIL full_latency: accepted=%b latency=%0d, want 1 and 4", ok, lat);
    end
    tests++;
    if (NewState !== VecOut) begin
      fails++;
      $display("FAIL full_state: NewState=%h, want %h", NewState, VecOut);
    end
    drain();
  endtask

  task automatic test_fixed_points();
    bit ok;
    int lat;
    accept(VecFixed, ok);
    wait_out(lat);
    tests++;
    if (!ok || lat != 4 || NewState !== VecFixed) begin
      fails++;
      $display("FAIL fixed_point: NewState=%h latency=%0d, want %h and 4", NewState, lat, VecFixed);
    end
    drain();
  endtask

  task automatic test_round_trip();
    bit ok;
    int lat;
    logic [127:0] x;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      accept(mix_columns(x), ok);
      wait_out(lat);
      tests++;
      if (!ok || lat != 4 || NewState !== x) begin
        fails++;
        $display("FAIL round_trip[%0d]: NewState=%h latency=%0d, want %h and 4", i, NewState, lat, x);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad;
    accept(VecIn, ok);
    wait_out(lat);
    tests++;
    if (!ok || lat != 4) begin
      fails++;
      $display("FAIL bp_first_latency: latency=%0d, want 4", lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state = VecFixed;
      #1;
      if (out_valid !== 1'b1 || NewState !== VecOut || in_ready !== 1'b0) bad++;
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0 || out_valid !== 1'b1 || NewState !== VecOut) begin
      fails++;
      $display("FAIL bp_stable: %0d unstable cycles, NewState=%h, want 0 and %h",
               bad, NewState, VecOut);
    end
    // Drain and accept the next vector on the same edge
    in_valid = 1'b1;
    state = VecFixed;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_in_ready: in_ready=%b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    state = '0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy: out_valid=%b in_ready=%b, want 0 and 0", out_valid, in_ready);
    end
    wait_out(lat);
    tests++;
    if (lat != 4 || NewState !== VecFixed) begin
      fails++;
      $display("FAIL b2b_result: latency=%0d NewState=%h, want 4 and %h", lat, NewState, VecFixed);
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int stale;
    accept(VecIn, ok);
    step();
    step();
    // Counter now points at column 2
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || NewState !== '0) begin
      fails++;
      $display("FAIL midreset_async: out_valid=%b NewState=%h, want 0 and 0", out_valid, NewState);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_ready: in_ready=%b, want 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || NewState !== '0) stale++;
      step();
    end
    tests++;
    if (stale != 0) begin
      fails++;
      $display("FAIL midreset_stale: %0d cycles with a result, want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_full_state();
    test_fixed_points();
    test_backpressure();
    test_round_trip();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
